// File: rtl/y86_decode_wb.sv
// Y86 decode / write-back stage: register file with valE/valM write-back,
// same-edge bypass into the operand reads, and a one-entry registered output.
module y86_decode_wb #(
   parameter int WIDTH  = 64,
   parameter int NREGS  = 15,
   parameter int RSP_ID = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [3:0]       icode_i,
   input  logic [3:0]       ifun_i,
   input  logic [3:0]       ra_i,
   input  logic [3:0]       rb_i,
   input  logic             wb_valid_i,
   input  logic [3:0]       wb_icode_i,
   input  logic [3:0]       wb_ra_i,
   input  logic [3:0]       wb_rb_i,
   input  logic             wb_cnd_i,
   input  logic [WIDTH-1:0] wb_vale_i,
   input  logic [WIDTH-1:0] wb_valm_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [3:0]       out_icode_o,
   output logic [3:0]       out_ifun_o,
   output logic [WIDTH-1:0] vala_o,
   output logic [WIDTH-1:0] valb_o,
   output logic [3:0]       dste_o,
   output logic [3:0]       dstm_o
);

   localparam logic [3:0] RNONE  = 4'hF;
   localparam logic [3:0] RSP    = 4'(RSP_ID);
   localparam logic [4:0] NREGS5 = 5'(NREGS);

   function automatic logic [3:0] src_a(input logic [3:0] ic, input logic [3:0] ra);
      case (ic)
         4'h2, 4'h4, 4'h6, 4'hA: src_a = ra;
         4'h9, 4'hB:             src_a = RSP;
         default:                src_a = RNONE;
      endcase
   endfunction

   function automatic logic [3:0] src_b(input logic [3:0] ic, input logic [3:0] rb);
      case (ic)
         4'h4, 4'h5, 4'h6:       src_b = rb;
         4'h8, 4'h9, 4'hA, 4'hB: src_b = RSP;
         default:                src_b = RNONE;
      endcase
   endfunction

   function automatic logic [3:0] dst_e(input logic [3:0] ic, input logic [3:0] rb);
      case (ic)
         4'h2, 4'h3, 4'h6:       dst_e = rb;
         4'h8, 4'h9, 4'hA, 4'hB: dst_e = RSP;
         default:                dst_e = RNONE;
      endcase
   endfunction

   function automatic logic [3:0] dst_m(input logic [3:0] ic, input logic [3:0] ra);
      case (ic)
         4'h5, 4'hB: dst_m = ra;
         default:    dst_m = RNONE;
      endcase
   endfunction

   function automatic logic in_rf(input logic [3:0] id);
      in_rf = {1'b0, id} < NREGS5;
   endfunction

   logic [WIDTH-1:0] regs_q [NREGS];
   logic [WIDTH-1:0] regs_d [NREGS];

   logic             out_valid_q, out_valid_d;
   logic [3:0]       icode_q, ifun_q, dste_q, dstm_q;
   logic [WIDTH-1:0] vala_q, valb_q, vala_d, valb_d;
   logic [3:0]       wb_dste, wb_dstm, srca, srcb;
   logic             accept;

   // A not-taken cmov drops its E write; M is applied last so it wins on dstE==dstM.
   always_comb begin
      wb_dste = RNONE;
      wb_dstm = RNONE;
      if (wb_valid_i) begin
         wb_dstm = dst_m(wb_icode_i, wb_ra_i);
         if (!(wb_icode_i == 4'h2 && !wb_cnd_i))
            wb_dste = dst_e(wb_icode_i, wb_rb_i);
      end
      for (int i = 0; i < NREGS; i++) begin
         regs_d[i] = regs_q[i];
         if (wb_dstm == 4'(i))
            regs_d[i] = wb_valm_i;
         else if (wb_dste == 4'(i))
            regs_d[i] = wb_vale_i;
      end
   end

   // Reads come from the post-write view so a same-edge write is visible.
   always_comb begin
      srca   = src_a(icode_i, ra_i);
      srcb   = src_b(icode_i, rb_i);
      vala_d = in_rf(srca) ? regs_d[srca] : '0;
      valb_d = in_rf(srcb) ? regs_d[srcb] : '0;
   end

   assign in_ready_o  = !out_valid_q || out_ready_i;
   assign accept      = in_valid_i && in_ready_o;
   assign out_valid_d = accept || (out_valid_q && !out_ready_i);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
         out_valid_q <= 1'b0;
         icode_q     <= '0;
         ifun_q      <= '0;
         vala_q      <= '0;
         valb_q      <= '0;
         dste_q      <= RNONE;
         dstm_q      <= RNONE;
      end else begin
         regs_q      <= regs_d;
         out_valid_q <= out_valid_d;
         if (accept) begin
            icode_q <= icode_i;
            ifun_q  <= ifun_i;
            vala_q  <= vala_d;
            valb_q  <= valb_d;
            dste_q  <= dst_e(icode_i, rb_i);
            dstm_q  <= dst_m(icode_i, ra_i);
         end
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_icode_o = icode_q;
   assign out_ifun_o  = ifun_q;
   assign vala_o      = vala_q;
   assign valb_o      = valb_q;
   assign dste_o      = dste_q;
   assign dstm_o      = dstm_q;

endmodule

// File: tb/tb_y86_decode_wb.sv
// Scoreboard bench for y86_decode_wb: directed decode/write-back vectors,
// expected bundles queued at accept and checked by an independent monitor.
module tb_y86_decode_wb;

   typedef struct {
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [63:0] a;
      logic [63:0] b;
      logic [3:0]  de;
      logic [3:0]  dm;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, in_ready;
   logic [3:0]  icode = '0, ifun = '0, ra = 4'hF, rb = 4'hF;
   logic        wb_valid = 1'b0, wb_cnd = 1'b0;
   logic [3:0]  wb_icode = '0, wb_ra = 4'hF, wb_rb = 4'hF;
   logic [63:0] wb_vale = '0, wb_valm = '0;
   logic        out_valid, out_ready = 1'b1;
   logic [3:0]  out_icode, out_ifun, dste, dstm;
   logic [63:0] vala, valb;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;

   y86_decode_wb #(.WIDTH(64), .NREGS(15), .RSP_ID(4)) dut (
      .clk_i(clk), .rst_i(rst),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .icode_i(icode), .ifun_i(ifun), .ra_i(ra), .rb_i(rb),
      .wb_valid_i(wb_valid), .wb_icode_i(wb_icode), .wb_ra_i(wb_ra), .wb_rb_i(wb_rb),
      .wb_cnd_i(wb_cnd), .wb_vale_i(wb_vale), .wb_valm_i(wb_valm),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_icode_o(out_icode), .out_ifun_o(out_ifun),
      .vala_o(vala), .valb_o(valb), .dste_o(dste), .dstm_o(dstm)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Every transfer (valid & ready before the edge) must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         n_chk++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_bundle: got icode=%0h valA=%0h with nothing expected", out_icode, vala);
         end else begin
            e = sb.pop_front();
            if ({out_icode, out_ifun, vala, valb, dste, dstm} !== {e.icode, e.ifun, e.a, e.b, e.de, e.dm}) begin
               n_fail++;
               $display("FAIL bundle: got ic=%0h fn=%0h A=%0h B=%0h dE=%0h dM=%0h, expected ic=%0h fn=%0h A=%0h B=%0h dE=%0h dM=%0h",
                        out_icode, out_ifun, vala, valb, dste, dstm, e.icode, e.ifun, e.a, e.b, e.de, e.dm);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_wb(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                         input logic c, input logic [63:0] ve, input logic [63:0] vm);
      wb_icode = ic; wb_ra = a; wb_rb = b; wb_cnd = c; wb_vale = ve; wb_valm = vm;
      wb_valid = 1'b1;
   endtask

   task automatic wb(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                     input logic c, input logic [63:0] ve, input logic [63:0] vm);
      set_wb(ic, a, b, c, ve, vm);
      tick();
      wb_valid = 1'b0;
   endtask

   // Present one instruction until accepted; any write-back already set up rides along.
   task automatic dec(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] a, input logic [3:0] b,
                      input logic [63:0] ea, input logic [63:0] eb,
                      input logic [3:0] de, input logic [3:0] dm, input bit push);
      bit done = 1'b0;
      icode = ic; ifun = fn; ra = a; rb = b;
      in_valid = 1'b1;
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge clk);
         if (in_ready) begin
            if (push) sb.push_back('{ic, fn, ea, eb, de, dm});
            done = 1'b1;
         end
         tick();
      end
      if (!done) begin
         n_chk++;
         n_fail++;
         $display("FAIL accept_timeout: got in_ready=0 for 20 cycles expected 1");
      end
      in_valid = 1'b0;
      wb_valid = 1'b0;
   endtask

   initial begin
      // Reset with a write and an instruction presented: both must be ignored.
      set_wb(4'h3, 4'hF, 4'h1, 1'b1, 64'hDEAD, 64'h0);
      icode = 4'h2; ra = 4'h1; in_valid = 1'b1;
      repeat (3) tick();
      in_valid = 1'b0; wb_valid = 1'b0;
      rst = 1'b0;
      tick();
      chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
      chk("rst_in_ready",  {63'b0, in_ready},  64'd1);
      chk("rst_valA", vala, 64'd0);
      chk("rst_valB", valb, 64'd0);
      chk("rst_icode", {60'b0, out_icode}, 64'd0);
      chk("rst_ifun",  {60'b0, out_ifun},  64'd0);
      chk("rst_dstE",  {60'b0, dste}, 64'hF);
      chk("rst_dstM",  {60'b0, dstm}, 64'hF);
      dec(4'h6, 4'h0, 4'h1, 4'h1, 64'h0, 64'h0, 4'h1, 4'hF, 1);

      // irmovq into r2, then consumers
      wb(4'h3, 4'hF, 4'h2, 1'b1, 64'h55, 64'h0);
      dec(4'h2, 4'h0, 4'h2, 4'h7, 64'h55, 64'h0, 4'h7, 4'hF, 1);
      dec(4'h0, 4'h0, 4'h1, 4'h1, 64'h0,  64'h0, 4'hF, 4'hF, 1);

      // Same-edge bypass of r3
      set_wb(4'h6, 4'h0, 4'h3, 1'b1, 64'h7, 64'h0);
      dec(4'h6, 4'h1, 4'h3, 4'h3, 64'h7, 64'h7, 4'h3, 4'hF, 1);

      // cmov not taken leaves r5 at 0; taken writes r6
      wb(4'h2, 4'h1, 4'h5, 1'b0, 64'h99, 64'h0);
      dec(4'h6, 4'h0, 4'h5, 4'h5, 64'h0, 64'h0, 4'h5, 4'hF, 1);
      wb(4'h2, 4'h1, 4'h6, 1'b1, 64'h66, 64'h0);
      dec(4'h4, 4'h0, 4'h6, 4'h6, 64'h66, 64'h66, 4'hF, 4'hF, 1);

      // popq %rsp: M beats E, both committed and bypassed
      wb(4'hB, 4'h4, 4'hF, 1'b1, 64'h100, 64'h200);
      dec(4'h9, 4'h0, 4'hF, 4'hF, 64'h200, 64'h200, 4'h4, 4'hF, 1);
      set_wb(4'hB, 4'h4, 4'hF, 1'b1, 64'h300, 64'h80);
      dec(4'h9, 4'h0, 4'hF, 4'hF, 64'h80, 64'h80, 4'h4, 4'hF, 1);

      // Stack ops with rsp=0x80, then mrmovq dstM
      wb(4'h3, 4'hF, 4'h1, 1'b1, 64'h11, 64'h0);
      dec(4'hA, 4'h0, 4'h1, 4'hF, 64'h11, 64'h80, 4'h4, 4'hF, 1);
      dec(4'h9, 4'h0, 4'hF, 4'hF, 64'h80, 64'h80, 4'h4, 4'hF, 1);
      dec(4'h5, 4'h0, 4'h3, 4'h2, 64'h0,  64'h55, 4'hF, 4'h3, 1);

      // Back-pressure: held bundle stays put even when r2 is rewritten
      tick();
      out_ready = 1'b0;
      dec(4'h2, 4'h0, 4'h2, 4'h0, 64'h55, 64'h0, 4'h0, 4'hF, 1);
      for (int k = 0; k < 3; k++) begin
         chk("hold_in_ready",  {63'b0, in_ready},  64'd0);
         chk("hold_out_valid", {63'b0, out_valid}, 64'd1);
         chk("hold_valA", vala, 64'h55);
         chk("hold_icode", {60'b0, out_icode}, 64'h2);
         chk("hold_dstE",  {60'b0, dste}, 64'h0);
         if (k == 0) set_wb(4'h3, 4'hF, 4'h2, 1'b1, 64'h77, 64'h0);
         tick();
         wb_valid = 1'b0;
      end
      out_ready = 1'b1;
      dec(4'h3, 4'h0, 4'hF, 4'h4, 64'h0,  64'h0,  4'h4, 4'hF, 1);
      chk("b2b_out_valid", {63'b0, out_valid}, 64'd1);
      dec(4'h6, 4'h0, 4'h2, 4'h2, 64'h77, 64'h77, 4'h2, 4'hF, 1);

      // Reset while a bundle is held
      tick();
      out_ready = 1'b0;
      dec(4'h6, 4'h0, 4'h1, 4'h1, 64'h11, 64'h11, 4'h1, 4'hF, 0);
      chk("pre_rst_out_valid", {63'b0, out_valid}, 64'd1);
      chk("pre_rst_in_ready",  {63'b0, in_ready},  64'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_out_valid", {63'b0, out_valid}, 64'd0);
      chk("mid_rst_in_ready",  {63'b0, in_ready},  64'd1);
      chk("mid_rst_dstE", {60'b0, dste}, 64'hF);
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++)
         dec(4'h6, 4'h0, 4'(i), 4'(i), 64'h0, 64'h0, 4'(i), 4'hF, 1);

      for (int k = 0; k < 50 && sb.size() != 0; k++) tick();
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
